// File: rtl/aad_window_ctrl_if.sv
// Bundle of the sample stream, result port and status lines of aad_window_ctrl.
//
// Handshake rule for both streams (in_valid/in_ready and out_valid/out_ready):
// a transfer happens on the rising clk edge where valid and ready are both 1;
// the producer keeps valid and payload stable until that edge, and valid never
// waits on ready.
interface aad_window_ctrl_if #(
    parameter int DW = 8,
    parameter int LW = 8,
    parameter int AW = 16
);
    logic          start;
    logic [LW-1:0] win_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] sad;
    logic [DW-1:0] mean;
    logic          busy;
    logic          err;
    logic [1:0]    state_dbg;

    modport master (
        output start, win_len, in_valid, a, b, out_ready,
        input  in_ready, out_valid, sad, mean, busy, err, state_dbg
    );

    modport slave (
        input  start, win_len, in_valid, a, b, out_ready,
        output in_ready, out_valid, sad, mean, busy, err, state_dbg
    );
endinterface

// File: rtl/aad_window_ctrl.sv
// Window controller: accumulates |a-b| over win_len beats, then divides the sum
// by win_len with a bit-serial restoring divider and offers {sad, mean}.
// AW must be at least DW+LW so the accumulator can never wrap.
module aad_window_ctrl #(
    parameter int DW = 8,
    parameter int LW = 8,
    parameter int AW = 16
) (
    input logic              clk,
    input logic              rst,
    aad_window_ctrl_if.slave bus
);

    // div_cnt 0 is the operand-load cycle, 1..AW are the quotient-bit cycles
    localparam int CW = $clog2(AW + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] acc;
    logic [AW-1:0] quot;
    logic [AW-1:0] sad_q;
    logic [DW-1:0] mean_q;
    logic [LW:0]   rem;
    logic [LW-1:0] len_q;
    logic [LW-1:0] count;
    logic [CW-1:0] div_cnt;
    logic          err_q;

    logic [DW-1:0] diff;
    logic          accept;
    logic          last_beat;
    logic          div_last;
    logic          start_ok;
    logic          start_zero;
    logic [LW+1:0] rem_shift;
    logic [LW:0]   rem_sub;
    logic          rem_ge;
    logic [AW-1:0] quot_shift;
    logic          in_ready_c;
    logic          out_valid_c;
    logic          busy_c;

    // Datapath helpers: unsigned absolute difference and one restoring-division step
    always_comb begin
        start_ok   = bus.start && (bus.win_len != '0);
        start_zero = bus.start && (bus.win_len == '0);
        diff       = (bus.a >= bus.b) ? (bus.a - bus.b) : (bus.b - bus.a);
        accept     = (state == ACCUM) && bus.in_valid;
        last_beat  = accept && (count == len_q - 1'b1);
        div_last   = (div_cnt == CW'(AW));
        rem_shift  = {rem, quot[AW-1]};
        rem_ge     = (rem_shift >= {2'b00, len_q});
        rem_sub    = rem_shift[LW:0] - {1'b0, len_q};
        quot_shift = {quot[AW-2:0], rem_ge};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and state-decoded handshake/status outputs
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (start_ok) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                if (last_beat) state_nxt = DIVIDE;
            end
            DIVIDE: begin
                if (div_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window capture, accumulation, division and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            count   <= '0;
            quot    <= '0;
            rem     <= '0;
            len_q   <= '0;
            div_cnt <= '0;
            sad_q   <= '0;
            mean_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start_zero;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q <= bus.win_len;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                ACCUM: begin
                    div_cnt <= '0;
                    if (accept) begin
                        acc   <= acc + AW'(diff);
                        count <= count + 1'b1;
                    end
                end
                DIVIDE: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == '0) begin
                        quot <= acc;
                        rem  <= '0;
                    end else begin
                        quot <= quot_shift;
                        rem  <= rem_ge ? rem_sub : rem_shift[LW:0];
                    end
                    // Each |a-b| term is below 2^DW, so the mean fits in DW bits
                    if (div_last) begin
                        sad_q  <= acc;
                        mean_q <= quot_shift[DW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.err       = err_q;
    assign bus.sad       = sad_q;
    assign bus.mean      = mean_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_aad_window_ctrl.sv
// Bench for aad_window_ctrl: table of directed windows, hand-written corner
// sequences (error start, long window, reset abort) and random windows checked
// against a sum/divide reference model.
module tb_aad_window_ctrl;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aad_window_ctrl_if #(.DW(DW), .LW(LW), .AW(AW)) bus ();

    aad_window_ctrl #(.DW(DW), .LW(LW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] exp_q[$];
    int               pa[$];
    int               pb[$];

    typedef struct {
        int len;
        int gap;
        int hold;
        bit mid_start;
        int a[4];
        int b[4];
        int exp_sad;
        int exp_mean;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic add_vec(input int len, input int gap, input int hold, input bit mid,
                           input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2, input int a3, input int b3,
                           input int s, input int m);
        vec_t v;
        v.len = len; v.gap = gap; v.hold = hold; v.mid_start = mid;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.exp_sad = s; v.exp_mean = m;
        vecs.push_back(v);
    endtask

    // Reference: sum of absolute differences and its floor mean over pa/pb
    function automatic logic [AW+DW-1:0] model(input int len);
        int s = 0;
        for (int i = 0; i < len; i++) s += (pa[i] > pb[i]) ? pa[i] - pb[i] : pb[i] - pa[i];
        return {AW'(s), DW'(s / len)};
    endfunction

    // Runs one window from start to result handshake using pa/pb as the beats
    task automatic do_window(input int len, input int gap, input int hold, input bit mid_start);
        int ready_cnt;
        int lat;
        bit got;
        logic [AW+DW-1:0] e;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.win_len = LW'(len);
        @(negedge clk);
        bus.start = 1'b0;
        ready_cnt = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0;
                    if (bus.in_ready) ready_cnt++;
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1;
            bus.a = DW'(pa[i]);
            bus.b = DW'(pb[i]);
            got = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                if (mid_start && i == 1 && w == 0) begin
                    bus.start   = 1'b1;
                    bus.win_len = LW'(7);
                end else begin
                    bus.start = 1'b0;
                end
                if (bus.in_ready) begin
                    ready_cnt++;
                    got = 1'b1;
                end
                @(negedge clk);
            end
            if (!got) begin
                total++; bad++;
                $display("FAIL accept_timeout beat=%0d got=no_ready exp=ready", i);
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.in_ready) ready_cnt++;
        end
        chk("latency", lat, AW + 1);
        chk("in_ready_cycles", ready_cnt, len + gap * (len - 1));
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL exp_q_empty got=0 exp=1");
            return;
        end
        e = exp_q[0];
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_sad", bus.sad, e[AW+DW-1:DW]);
            chk("hold_mean", bus.mean, e[DW-1:0]);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        e = exp_q.pop_front();
        chk("sad", bus.sad, e[AW+DW-1:DW]);
        chk("mean", bus.mean, e[DW-1:0]);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_drop", bus.out_valid, 0);
        chk("busy_idle", bus.busy, 0);
        chk("sad_kept", bus.sad, e[AW+DW-1:DW]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW+DW-1:0] e;
        int len;
        int gap;

        add_vec(4, 0, 0, 1'b0, 10, 3, 3, 10, 200, 0, 0, 0, 214, 53);
        add_vec(1, 0, 0, 1'b0, 255, 0, 0, 0, 0, 0, 0, 0, 255, 255);
        add_vec(3, 2, 0, 1'b0, 5, 1, 1, 5, 9, 9, 0, 0, 8, 2);
        add_vec(2, 0, 10, 1'b0, 100, 50, 60, 0, 0, 0, 0, 0, 110, 55);
        add_vec(3, 1, 0, 1'b1, 20, 10, 0, 30, 7, 7, 0, 0, 40, 13);

        // clock/reset
        rst = 1'b1;
        bus.start = 1'b0; bus.win_len = '0; bus.in_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_sad", bus.sad, 0);
        chk("rst_mean", bus.mean, 0);
        @(negedge clk);
        rst = 1'b0;

        // directed table
        foreach (vecs[k]) begin
            pa.delete(); pb.delete();
            for (int i = 0; i < vecs[k].len; i++) begin
                pa.push_back(vecs[k].a[i]);
                pb.push_back(vecs[k].b[i]);
            end
            exp_q.push_back({AW'(vecs[k].exp_sad), DW'(vecs[k].exp_mean)});
            do_window(vecs[k].len, vecs[k].gap, vecs[k].hold, vecs[k].mid_start);
        end

        // zero-length start: one-cycle err, nothing else moves
        @(negedge clk);
        bus.start = 1'b1; bus.win_len = '0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_pulse", bus.err, 1);
        chk("err_busy", bus.busy, 0);
        chk("err_in_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("err_clear", bus.err, 0);
        chk("err_busy2", bus.busy, 0);

        // longest window, maximal terms: no accumulator wrap
        pa.delete(); pb.delete();
        for (int i = 0; i < 255; i++) begin
            pa.push_back(0);
            pb.push_back(255);
        end
        exp_q.push_back({AW'(65025), DW'(255)});
        do_window(255, 0, 0, 1'b0);

        // reset after 2 of 4 beats aborts the window
        @(negedge clk);
        bus.start = 1'b1; bus.win_len = LW'(4);
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.a = DW'(9); bus.b = DW'(1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_err", bus.err, 0);
        chk("abort_sad", bus.sad, 0);
        chk("abort_mean", bus.mean, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pa.delete(); pb.delete();
        pa.push_back(7); pb.push_back(2);
        pa.push_back(2); pb.push_back(7);
        exp_q.push_back(model(2));
        do_window(2, 0, 0, 1'b0);

        // random windows against the reference model
        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(1, 12);
            gap = $urandom_range(0, 2);
            pa.delete(); pb.delete();
            for (int i = 0; i < len; i++) begin
                pa.push_back($urandom_range(0, 255));
                pb.push_back($urandom_range(0, 255));
            end
            e = model(len);
            exp_q.push_back(e);
            do_window(len, gap, $urandom_range(0, 3), 1'b0);
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
